clk_div_multi: RTL and testbench

- Parameterised multi-channel clock-enable divider; successor to the single fixed 1.5 Hz divider.
- Generates NUM_CH independent 50%-duty slow square waves plus single-cycle tick strobes from the 300 MHz system clock.
- Each channel's half-period is programmable at run time through a valid/ready config port.
- Sits between the board oscillator buffer and the LED/IO logic of the top level.

---
 rtl/clk_div_multi_if.sv | 27 ++
 rtl/clk_div_multi.sv | 105 ++++++++++
 tb/tb_clk_div_multi.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_multi_if.sv
// Config write port for clk_div_multi: valid/ready handshake carrying a
// channel index and a new half-period value.
interface clk_div_multi_if #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CH_W-1:0]      cfg_ch;
    logic [CNT_WIDTH-1:0] cfg_half_period;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_half_period,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_half_period,
        output cfg_ready
    );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable divider: per-channel 50% square wave
// plus tick strobe. Optional CLK_DIV_EDGE_COUNT_EN adds saturating rising-edge counters.
module clk_div_multi #(
    parameter int          NUM_CH              = 4,
    parameter int          CNT_WIDTH           = 32,
    parameter int unsigned DEFAULT_HALF_PERIOD = 100000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    ch_enable,
    input  logic                 sync_all,
    clk_div_multi_if.slave       cfg,
    output logic [NUM_CH-1:0]    clk_out,
    output logic [NUM_CH-1:0]    tick_out
`ifdef CLK_DIV_EDGE_COUNT_EN
    ,
    output logic [NUM_CH*16-1:0] edge_count
`endif
);

    localparam logic [CNT_WIDTH-1:0] DEF_HP = CNT_WIDTH'(DEFAULT_HALF_PERIOD);
    localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt       [NUM_CH];
    logic [CNT_WIDTH-1:0] active_hp [NUM_CH];
    logic [CNT_WIDTH-1:0] pend_hp   [NUM_CH];
    logic [CNT_WIDTH-1:0] h_last    [NUM_CH];
    logic [NUM_CH-1:0]    pend_vld;
    logic [NUM_CH-1:0]    wr_sel;
    logic [NUM_CH-1:0]    wrap;
    logic                 cfg_ready_q;
    logic                 accept;

    assign cfg.cfg_ready = cfg_ready_q;

    // Out-of-range channel indices match no wr_sel bit, so such writes vanish.
    always_comb begin
        accept = cfg.cfg_valid && cfg_ready_q;
        wr_sel = '0;
        wrap   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = accept && (32'(cfg.cfg_ch) == 32'(i));
            h_last[i] = (active_hp[i] == '0) ? '0 : active_hp[i] - ONE;
            wrap[i]   = ch_enable[i] && (cnt[i] == h_last[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_ready_q <= 1'b0;
            clk_out     <= '0;
            tick_out    <= '0;
            pend_vld    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]       <= '0;
                active_hp[i] <= DEF_HP;
                pend_hp[i]   <= '0;
            end
`ifdef CLK_DIV_EDGE_COUNT_EN
            edge_count  <= '0;
`endif
        end else begin
            cfg_ready_q <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_sel[i]) begin
                    pend_hp[i]  <= cfg.cfg_half_period;
                    pend_vld[i] <= 1'b1;
                end
                // A write landing on the same cycle as a wrap or sync is used directly.
                if (sync_all || wrap[i]) begin
                    if (wr_sel[i]) begin
                        active_hp[i] <= cfg.cfg_half_period;
                    end else if (pend_vld[i]) begin
                        active_hp[i] <= pend_hp[i];
                    end
                    pend_vld[i] <= 1'b0;
                end

                if (sync_all) begin
                    cnt[i]      <= '0;
                    clk_out[i]  <= 1'b0;
                    tick_out[i] <= 1'b0;
                end else if (wrap[i]) begin
                    cnt[i]      <= '0;
                    clk_out[i]  <= ~clk_out[i];
                    tick_out[i] <= 1'b1;
                end else begin
                    if (ch_enable[i]) begin
                        cnt[i] <= cnt[i] + ONE;
                    end
                    tick_out[i] <= 1'b0;
                end

`ifdef CLK_DIV_EDGE_COUNT_EN
                if (sync_all) begin
                    edge_count[i*16 +: 16] <= '0;
                end else if (wrap[i] && !clk_out[i] && (edge_count[i*16 +: 16] != 16'hFFFF)) begin
                    edge_count[i*16 +: 16] <= edge_count[i*16 +: 16] + 16'd1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed vector table and corner sequences on a
// 2-channel instance, randomized traffic against a reference model on a 3-channel one.
module tb_clk_div_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [1:0] en2, co2, to2;
    logic       sync2;
    logic [2:0] en3, co3, to3;
    logic       sync3;

    clk_div_multi_if #(.NUM_CH(2), .CNT_WIDTH(8)) if2 ();
    clk_div_multi_if #(.NUM_CH(3), .CNT_WIDTH(8)) if3 ();

`ifdef CLK_DIV_EDGE_COUNT_EN
    logic [31:0] ec2;
    logic [47:0] ec3;
`endif

    clk_div_multi #(.NUM_CH(2), .CNT_WIDTH(8), .DEFAULT_HALF_PERIOD(4)) u2 (
        .clk(clk), .reset(reset), .ch_enable(en2), .sync_all(sync2), .cfg(if2),
        .clk_out(co2), .tick_out(to2)
`ifdef CLK_DIV_EDGE_COUNT_EN
        , .edge_count(ec2)
`endif
    );

    clk_div_multi #(.NUM_CH(3), .CNT_WIDTH(8), .DEFAULT_HALF_PERIOD(4)) u3 (
        .clk(clk), .reset(reset), .ch_enable(en3), .sync_all(sync3), .cfg(if3),
        .clk_out(co3), .tick_out(to3)
`ifdef CLK_DIV_EDGE_COUNT_EN
        , .edge_count(ec3)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv2(input logic [1:0] en, input logic sy, input logic v,
                        input logic ch, input logic [7:0] hp);
        en2 = en; sync2 = sy;
        if2.cfg_valid = v; if2.cfg_ch = ch; if2.cfg_half_period = hp;
    endtask

    task automatic drv3(input logic [2:0] en, input logic sy, input logic v,
                        input logic [1:0] ch, input logic [7:0] hp);
        en3 = en; sync3 = sy;
        if3.cfg_valid = v; if3.cfg_ch = ch; if3.cfg_half_period = hp;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drv2(2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
        drv3(3'b000, 1'b0, 1'b0, 2'd0, 8'd0);
        step();
        step();
        reset = 1'b0;
    endtask

    // Reference model for the 3-channel instance: half-periods, cycles elapsed, levels.
    int m_cnt [3], m_hp [3], m_pend [3], m_edges [3];
    bit m_pv [3], m_lvl [3], m_tick [3];
    bit m_rdy;

    task automatic model_step(input bit rst, input logic [2:0] en, input bit sy,
                              input bit v, input int ch, input int hp);
        bit acc, wr;
        int h, newhp;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = 0; m_hp[i] = 4; m_pend[i] = 0; m_pv[i] = 0;
                m_lvl[i] = 0; m_tick[i] = 0; m_edges[i] = 0;
            end
            m_rdy = 0;
            return;
        end
        acc = v && m_rdy;
        for (int i = 0; i < 3; i++) begin
            wr    = acc && (ch == i);
            h     = (m_hp[i] == 0) ? 1 : m_hp[i];
            newhp = wr ? hp : (m_pv[i] ? m_pend[i] : m_hp[i]);
            if (sy) begin
                m_cnt[i] = 0; m_lvl[i] = 0; m_tick[i] = 0; m_edges[i] = 0;
                m_hp[i] = newhp; m_pv[i] = 0;
            end else if (en[i] && (m_cnt[i] + 1 == h)) begin
                m_cnt[i] = 0; m_lvl[i] = !m_lvl[i]; m_tick[i] = 1;
                if (m_lvl[i] && m_edges[i] < 65535) m_edges[i]++;
                m_hp[i] = newhp; m_pv[i] = 0;
            end else begin
                if (en[i]) m_cnt[i]++;
                m_tick[i] = 0;
                if (wr) begin m_pend[i] = hp; m_pv[i] = 1; end
            end
        end
        m_rdy = 1;
    endtask

    typedef struct {
        logic [1:0] en;
        logic       v;
        logic       ch;
        logic [7:0] hp;
        logic [1:0] exp_clk;
        logic [1:0] exp_tick;
    } vec_t;

    vec_t tbl [40];

    logic [1:0] s3_clk  [5] = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b01};
    logic [1:0] s3_tick [5] = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b11};

    initial begin
        // Steady divide-by-4 on both channels, then ch1 reprogrammed to 2 at counter=1.
        for (int k = 1; k <= 40; k++) begin
            tbl[k-1].en = 2'b11;
            tbl[k-1].v  = (k == 26);
            tbl[k-1].ch = 1'b1;
            tbl[k-1].hp = 8'd2;
            tbl[k-1].exp_clk[0]  = ((k / 4) % 2) == 1;
            tbl[k-1].exp_tick[0] = (k % 4) == 0;
            if (k <= 28) begin
                tbl[k-1].exp_clk[1]  = ((k / 4) % 2) == 1;
                tbl[k-1].exp_tick[1] = (k % 4) == 0;
            end else begin
                tbl[k-1].exp_clk[1]  = ((1 + (k - 28) / 2) % 2) == 1;
                tbl[k-1].exp_tick[1] = (k % 2) == 0;
            end
        end

        reset = 1'b1;
        drv2(2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
        drv3(3'b000, 1'b0, 1'b0, 2'd0, 8'd0);
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            step();
            chk($sformatf("rst_clk_r%0d", r), 64'(co2), 64'd0);
            chk($sformatf("rst_tick_r%0d", r), 64'(to2), 64'd0);
            chk($sformatf("rst_ready_r%0d", r), 64'(if2.cfg_ready), 64'd0);
        end
        reset = 1'b0;

        for (int k = 0; k < 40; k++) begin
            drv2(tbl[k].en, 1'b0, tbl[k].v, tbl[k].ch, tbl[k].hp);
            step();
            chk($sformatf("tbl_clk_k%0d", k + 1), 64'(co2), 64'(tbl[k].exp_clk));
            chk($sformatf("tbl_tick_k%0d", k + 1), 64'(to2), 64'(tbl[k].exp_tick));
            chk($sformatf("tbl_ready_k%0d", k + 1), 64'(if2.cfg_ready), 64'd1);
        end

        // ch0 half-period 0 acts as 1 once the current half completes.
        do_reset();
        drv2(2'b11, 1'b0, 1'b0, 1'b0, 8'd0); step();
        drv2(2'b11, 1'b0, 1'b1, 1'b0, 8'd0); step();
        drv2(2'b11, 1'b0, 1'b0, 1'b0, 8'd0); step();
        for (int e = 4; e <= 8; e++) begin
            step();
            chk($sformatf("hp0_clk_e%0d", e), 64'(co2), 64'(s3_clk[e-4]));
            chk($sformatf("hp0_tick_e%0d", e), 64'(to2), 64'(s3_tick[e-4]));
        end

        // Out-of-range channel index on the 3-channel instance is dropped.
        do_reset();
        drv3(3'b111, 1'b0, 1'b0, 2'd0, 8'd0); step();
        drv3(3'b111, 1'b0, 1'b1, 2'd3, 8'd1); step();
        chk("oor_ready_e2", 64'(if3.cfg_ready), 64'd1);
        drv3(3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
        for (int e = 3; e <= 8; e++) begin
            step();
            chk($sformatf("oor_tick_e%0d", e), 64'(to3), (e == 4 || e == 8) ? 64'h7 : 64'h0);
            chk($sformatf("oor_ready_e%0d", e), 64'(if3.cfg_ready), 64'd1);
        end
        chk("oor_clk_e8", 64'(co3), 64'h0);

        // ch0 disabled at counter=2 for 10 cycles, then resumes from the held count.
        do_reset();
        drv2(2'b11, 1'b0, 1'b0, 1'b0, 8'd0); step(); step();
        drv2(2'b10, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int e = 3; e <= 12; e++) begin
            step();
            chk($sformatf("dis_clk0_e%0d", e), 64'(co2[0]), 64'd0);
            chk($sformatf("dis_tick0_e%0d", e), 64'(to2[0]), 64'd0);
        end
        drv2(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
        step();
        chk("reen_tick0_e13", 64'(to2[0]), 64'd0);
        step();
        chk("reen_clk0_e14", 64'(co2[0]), 64'd1);
        chk("reen_tick0_e14", 64'(to2[0]), 64'd1);

        // Offset channels, sync_all with pending ch1=6, then reset discards a pending ch0 write.
        do_reset();
        drv2(2'b01, 1'b0, 1'b0, 1'b0, 8'd0); step(); step();
        drv2(2'b11, 1'b0, 1'b1, 1'b1, 8'd6); step();
        drv2(2'b11, 1'b1, 1'b0, 1'b0, 8'd0); step();
        chk("sync_clk_e4", 64'(co2), 64'd0);
        chk("sync_tick_e4", 64'(to2), 64'd0);
        drv2(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int e = 5; e <= 10; e++) begin
            step();
            chk($sformatf("sync_clk_e%0d", e), 64'(co2), 64'({e >= 10, e >= 8}));
            chk($sformatf("sync_tick_e%0d", e), 64'(to2), 64'({e == 10, e == 8}));
        end
        drv2(2'b11, 1'b0, 1'b1, 1'b0, 8'd2); step();
        reset = 1'b1;
        drv2(2'b11, 1'b0, 1'b0, 1'b0, 8'd0); step(); step();
        reset = 1'b0;
        for (int r = 1; r <= 8; r++) begin
            step();
            chk($sformatf("post_rst_tick0_r%0d", r), 64'(to2[0]), 64'(r == 4 || r == 8));
            chk($sformatf("post_rst_clk0_r%0d", r), 64'(co2[0]), 64'(r >= 4 && r < 8));
        end

        // Randomized traffic on the 3-channel instance against the model.
        drv2(2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
        do_reset();
        model_step(1'b1, 3'b000, 1'b0, 1'b0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            logic [2:0] ren;
            bit rrst, rsy, rv;
            int rch, rhp;
            rrst = ($urandom_range(0, 199) == 0);
            for (int b = 0; b < 3; b++) ren[b] = ($urandom_range(0, 9) != 0);
            rsy  = ($urandom_range(0, 49) == 0);
            rv   = ($urandom_range(0, 4) == 0);
            rch  = int'($urandom_range(0, 3));
            rhp  = int'($urandom_range(0, 7));
            reset = rrst;
            drv3(ren, rsy, rv, 2'(rch), 8'(rhp));
            model_step(rrst, ren, rsy, rv, rch, rhp);
            step();
            chk($sformatf("rnd_c%0d", c), 64'({if3.cfg_ready, co3, to3}),
                64'({m_rdy, m_lvl[2], m_lvl[1], m_lvl[0], m_tick[2], m_tick[1], m_tick[0]}));
`ifdef CLK_DIV_EDGE_COUNT_EN
            chk($sformatf("rnd_edges_c%0d", c), 64'(ec3),
                64'({16'(m_edges[2]), 16'(m_edges[1]), 16'(m_edges[0])}));
`endif
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
